// File: rtl/alpu_seq_pkg.sv
// Shared types and ctrl-word constants for the alpu_comb sequencing controller.
package alpu_seq_pkg;

  typedef enum logic [2:0] {
    OpAdd     = 3'd0,
    OpSub     = 3'd1,
    OpAnd     = 3'd2,
    OpOr      = 3'd3,
    OpXor     = 3'd4,
    OpNot     = 3'd5,
    OpPassB   = 3'd6,
    OpIllegal = 3'd7
  } alpu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExecLo,
    StExecHi,
    StResp
  } alpu_seq_state_e;

  // Bit 7..0: twos_en, all_en, cgen_en, or_en, carry_en, sel_sum, sel_cgen, out_inv
  localparam logic [7:0] CTRL_ADD   = 8'h2C;
  localparam logic [7:0] CTRL_SUB   = 8'hAC;
  localparam logic [7:0] CTRL_AND   = 8'h22;
  localparam logic [7:0] CTRL_OR    = 8'h32;
  localparam logic [7:0] CTRL_XOR   = 8'h04;
  localparam logic [7:0] CTRL_NOT   = 8'h44;
  localparam logic [7:0] CTRL_PASSB = 8'h24;

endpackage

// File: rtl/alpu_seq_decode.sv
// Combinational opcode decoder: maps an ALPU opcode to its alpu_comb ctrl word.
module alpu_seq_decode
  import alpu_seq_pkg::*;
(
  input  alpu_op_e    op_i,
  output logic [7:0]  ctrl_o,
  output logic        illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    unique case (op_i)
      OpAdd:   ctrl_o = CTRL_ADD;
      OpSub:   ctrl_o = CTRL_SUB;
      OpAnd:   ctrl_o = CTRL_AND;
      OpOr:    ctrl_o = CTRL_OR;
      OpXor:   ctrl_o = CTRL_XOR;
      OpNot:   ctrl_o = CTRL_NOT;
      OpPassB: ctrl_o = CTRL_PASSB;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alpu_seq.sv
// Sequencing controller in front of alpu_comb: single-beat ops and two-beat carry-chained ADD.
// Optional rsp_zero/rsp_neg flag outputs are enabled by defining ALPU_SEQ_FLAGS_EN.
module alpu_seq
  import alpu_seq_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,

  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [2:0]             req_op_i,
  input  logic                   req_wide_i,
  input  logic [2*REG_WIDTH-1:0] req_a_i,
  input  logic [2*REG_WIDTH-1:0] req_b_i,
  input  logic [TAG_WIDTH-1:0]   req_tag_i,

  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [2*REG_WIDTH-1:0] rsp_data_o,
  output logic                   rsp_cout_o,
  output logic                   rsp_err_o,
  output logic [TAG_WIDTH-1:0]   rsp_tag_o,
`ifdef ALPU_SEQ_FLAGS_EN
  output logic                   rsp_zero_o,
  output logic                   rsp_neg_o,
`endif

  output logic [REG_WIDTH-1:0]   alpu_a_o,
  output logic [REG_WIDTH-1:0]   alpu_b_o,
  output logic [7:0]             alpu_ctrl_o,
  output logic                   alpu_cin_o,
  input  logic [REG_WIDTH-1:0]   alpu_out_i,
  input  logic                   alpu_cout_i
);

  alpu_seq_state_e        state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic [2*REG_WIDTH-1:0] data_q;
  logic                   cout_q;
  logic                   err_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   wide_q;
  logic [REG_WIDTH-1:0]   a_hi_q;
  logic [REG_WIDTH-1:0]   b_hi_q;
  logic [REG_WIDTH-1:0]   alpu_a_q;
  logic [REG_WIDTH-1:0]   alpu_b_q;
  logic [7:0]             alpu_ctrl_q;
  logic                   alpu_cin_q;
`ifdef ALPU_SEQ_FLAGS_EN
  logic                   zero_q;
  logic                   neg_q;
`endif

  alpu_op_e   req_op;
  logic [7:0] dec_ctrl;
  logic       dec_illegal;
  logic       req_err;
  logic       req_hs;

  assign req_op = alpu_op_e'(req_op_i);

  alpu_seq_decode u_decode (
    .op_i      (req_op),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Only ADD has a carry chain, so any other wide request is rejected.
  assign req_err = dec_illegal | (req_wide_i & (req_op != OpAdd));
  assign req_hs  = req_valid_i & req_ready_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      tag_q       <= '0;
      wide_q      <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      alpu_a_q    <= '0;
      alpu_b_q    <= '0;
      alpu_ctrl_q <= '0;
      alpu_cin_q  <= 1'b0;
`ifdef ALPU_SEQ_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_hs) begin
            req_ready_q <= 1'b0;
            tag_q       <= req_tag_i;
            data_q      <= '0;
            cout_q      <= 1'b0;
`ifdef ALPU_SEQ_FLAGS_EN
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
`endif
            if (req_err) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q       <= 1'b0;
              wide_q      <= req_wide_i;
              a_hi_q      <= req_a_i[2*REG_WIDTH-1 -: REG_WIDTH];
              b_hi_q      <= req_b_i[2*REG_WIDTH-1 -: REG_WIDTH];
              alpu_a_q    <= req_a_i[REG_WIDTH-1:0];
              alpu_b_q    <= req_b_i[REG_WIDTH-1:0];
              alpu_ctrl_q <= dec_ctrl;
              alpu_cin_q  <= 1'b0;
              state_q     <= StExecLo;
            end
          end
        end
        StExecLo: begin
          data_q[REG_WIDTH-1:0] <= alpu_out_i;
          if (wide_q) begin
            // alpu_cin_q doubles as the inter-beat carry register.
            alpu_a_q    <= a_hi_q;
            alpu_b_q    <= b_hi_q;
            alpu_ctrl_q <= CTRL_ADD;
            alpu_cin_q  <= alpu_cout_i;
            state_q     <= StExecHi;
          end else begin
            cout_q      <= alpu_cout_i;
            alpu_ctrl_q <= '0;
            alpu_cin_q  <= 1'b0;
`ifdef ALPU_SEQ_FLAGS_EN
            zero_q      <= (alpu_out_i == '0);
            neg_q       <= alpu_out_i[REG_WIDTH-1];
`endif
            state_q     <= StResp;
          end
        end
        StExecHi: begin
          data_q[2*REG_WIDTH-1 -: REG_WIDTH] <= alpu_out_i;
          cout_q      <= alpu_cout_i;
          alpu_ctrl_q <= '0;
          alpu_cin_q  <= 1'b0;
`ifdef ALPU_SEQ_FLAGS_EN
          zero_q      <= ({alpu_out_i, data_q[REG_WIDTH-1:0]} == '0);
          neg_q       <= alpu_out_i[REG_WIDTH-1];
`endif
          state_q     <= StResp;
        end
        StResp: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_err_o   = err_q;
  assign rsp_tag_o   = tag_q;
`ifdef ALPU_SEQ_FLAGS_EN
  assign rsp_zero_o  = zero_q;
  assign rsp_neg_o   = neg_q;
`endif
  assign alpu_a_o    = alpu_a_q;
  assign alpu_b_o    = alpu_b_q;
  assign alpu_ctrl_o = alpu_ctrl_q;
  assign alpu_cin_o  = alpu_cin_q;

endmodule

// File: tb/tb_alpu_seq.sv
// Directed self-checking bench for alpu_seq with a behavioural alpu_comb attached.
module tb_alpu_seq;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_wide;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_cout;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
`ifdef ALPU_SEQ_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_neg;
`endif
  logic [15:0] alpu_a;
  logic [15:0] alpu_b;
  logic [7:0]  alpu_ctrl;
  logic        alpu_cin;
  logic [15:0] alpu_out;
  logic        alpu_cout;
  logic [16:0] alpu_sum;

  int checks = 0;
  int errors = 0;

  alpu_seq #(
    .REG_WIDTH (16),
    .TAG_WIDTH (4)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_wide_i  (req_wide),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_tag_i   (req_tag),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_cout_o  (rsp_cout),
    .rsp_err_o   (rsp_err),
    .rsp_tag_o   (rsp_tag),
`ifdef ALPU_SEQ_FLAGS_EN
    .rsp_zero_o  (rsp_zero),
    .rsp_neg_o   (rsp_neg),
`endif
    .alpu_a_o    (alpu_a),
    .alpu_b_o    (alpu_b),
    .alpu_ctrl_o (alpu_ctrl),
    .alpu_cin_o  (alpu_cin),
    .alpu_out_i  (alpu_out),
    .alpu_cout_i (alpu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alpu_comb; SUB yields b - a.
  always_comb begin
    alpu_sum = '0;
    case (alpu_ctrl)
      8'h2C:   alpu_sum = {1'b0, alpu_a} + {1'b0, alpu_b} + {16'd0, alpu_cin};
      8'hAC:   alpu_sum = {1'b0, alpu_b} + {1'b0, ~alpu_a} + 17'd1;
      8'h22:   alpu_sum = {1'b0, alpu_a & alpu_b};
      8'h32:   alpu_sum = {1'b0, alpu_a | alpu_b};
      8'h04:   alpu_sum = {1'b0, alpu_a ^ alpu_b};
      8'h44:   alpu_sum = {1'b0, ~alpu_a};
      8'h24:   alpu_sum = {1'b0, alpu_b};
      default: alpu_sum = '0;
    endcase
  end
  assign alpu_out  = alpu_sum[15:0];
  assign alpu_cout = alpu_sum[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and return just after its accept edge (edge 0).
  task automatic send(input logic [2:0] op, input logic wide, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_wide  = wide;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_wide  = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alpu_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    chk("rst_alpu_a", {16'd0, alpu_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Narrow ADD 00FF + 0001
    send(3'd0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 4'h5);
    chk("add_lo_ctrl", {24'd0, alpu_ctrl}, 32'h2C);
    chk("add_lo_a", {16'd0, alpu_a}, 32'h00FF);
    chk("add_lo_cin", {31'd0, alpu_cin}, 32'd0);
    chk("add_busy_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("add_e1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_e1_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    tick();
    chk("add_e2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_data", rsp_data, 32'h0000_0100);
    chk("add_cout", {31'd0, rsp_cout}, 32'd0);
    chk("add_err", {31'd0, rsp_err}, 32'd0);
    chk("add_tag", {28'd0, rsp_tag}, 32'h5);
`ifdef ALPU_SEQ_FLAGS_EN
    chk("add_zero", {31'd0, rsp_zero}, 32'd0);
`endif
    tick();
    chk("add_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_done_ready", {31'd0, req_ready}, 32'd1);

    // Wide ADD FFFF_FFFF + 1: carry out of both halves
    send(3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'h3);
    tick();
    chk("wovf_hi_cin", {31'd0, alpu_cin}, 32'd1);
    tick();
    tick();
    chk("wovf_e3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wovf_data", rsp_data, 32'd0);
    chk("wovf_cout", {31'd0, rsp_cout}, 32'd1);
`ifdef ALPU_SEQ_FLAGS_EN
    chk("wovf_zero", {31'd0, rsp_zero}, 32'd1);
    chk("wovf_neg", {31'd0, rsp_neg}, 32'd0);
`endif
    tick();

    // Wide ADD 0000_FFFF + 1: carry from low into high beat
    send(3'd0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 4'h6);
    chk("wadd_lo_a", {16'd0, alpu_a}, 32'hFFFF);
    tick();
    chk("wadd_hi_cin", {31'd0, alpu_cin}, 32'd1);
    chk("wadd_hi_ctrl", {24'd0, alpu_ctrl}, 32'h2C);
    chk("wadd_hi_a", {16'd0, alpu_a}, 32'h0000);
    tick();
    chk("wadd_e2_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("wadd_e3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wadd_data", rsp_data, 32'h0001_0000);
    chk("wadd_cout", {31'd0, rsp_cout}, 32'd0);
    chk("wadd_tag", {28'd0, rsp_tag}, 32'h6);
    tick();

    // Narrow SUB: b - a = 1 - 2
    send(3'd1, 1'b0, 32'h0000_0002, 32'h0000_0001, 4'h2);
    chk("sub_ctrl", {24'd0, alpu_ctrl}, 32'hAC);
    tick();
    tick();
    chk("sub_data", rsp_data, 32'h0000_FFFF);
    chk("sub_cout", {31'd0, rsp_cout}, 32'd0);
`ifdef ALPU_SEQ_FLAGS_EN
    chk("sub_neg", {31'd0, rsp_neg}, 32'd1);
    chk("sub_zero", {31'd0, rsp_zero}, 32'd0);
`endif
    tick();

    // Illegal opcode
    send(3'd7, 1'b0, 32'h0000_1234, 32'h0000_5678, 4'h9);
    chk("ill_e0_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    chk("ill_e0_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("ill_e1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ill_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_data", rsp_data, 32'd0);
    chk("ill_cout", {31'd0, rsp_cout}, 32'd0);
    chk("ill_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    chk("ill_tag", {28'd0, rsp_tag}, 32'h9);
    tick();

    // Wide SUB is illegal
    send(3'd1, 1'b1, 32'h0001_0000, 32'h0002_0000, 4'hA);
    chk("wsub_e0_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    tick();
    chk("wsub_e1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wsub_err", {31'd0, rsp_err}, 32'd1);
    chk("wsub_data", rsp_data, 32'd0);
    chk("wsub_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    tick();

    // Back-pressure on AND with a competing request held valid
    rsp_ready = 1'b0;
    send(3'd2, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 4'h4);
    chk("and_ctrl", {24'd0, alpu_ctrl}, 32'h22);
    tick();
    tick();
    chk("and_e2_valid", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b1;
    req_op    = 3'd3;
    req_wide  = 1'b0;
    req_a     = 32'h0000_000F;
    req_b     = 32'h0000_00F0;
    req_tag   = 4'hC;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'h0000_F000);
      chk("bp_tag", {28'd0, rsp_tag}, 32'h4);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_hs_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_hs_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("or_acc_ready", {31'd0, req_ready}, 32'd0);
    chk("or_acc_ctrl", {24'd0, alpu_ctrl}, 32'h32);
    tick();
    tick();
    chk("or_valid", {31'd0, rsp_valid}, 32'd1);
    chk("or_data", rsp_data, 32'h0000_00FF);
    chk("or_tag", {28'd0, rsp_tag}, 32'hC);
    tick();

    // Reset asserted during the high beat of a wide ADD
    send(3'd0, 1'b1, 32'h1234_8000, 32'h1111_8000, 4'hF);
    tick();
    chk("rmid_hi_cin", {31'd0, alpu_cin}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rmid_ctrl", {24'd0, alpu_ctrl}, 32'd0);
    chk("rmid_cin", {31'd0, alpu_cin}, 32'd0);
    chk("rmid_a", {16'd0, alpu_a}, 32'd0);
    chk("rmid_b", {16'd0, alpu_b}, 32'd0);
    chk("rmid_data", rsp_data, 32'd0);
    chk("rmid_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rmid_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rmid_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rrel_ready", {31'd0, req_ready}, 32'd1);
    chk("rrel_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rrel_no_stale", {31'd0, rsp_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alpu_seq.md
Name: alpu_seq

Overview:
- Sequencing controller in front of alpu_comb: accepts operation requests over a valid/ready handshake and decodes each opcode into the 8-bit alpu_comb ctrl word.
- Steps the datapath for single-beat (REG_WIDTH) operations or two-beat (2*REG_WIDTH) carry-chained ADD, registers the result, and returns it over a valid/ready response handshake.
- Sits between the issue stage and the combinational ALPU inside alpuWithCache.

Parameters:
- REG_WIDTH, 16, datapath width of the attached alpu_comb.
- TAG_WIDTH, 4, width of the request tag echoed on the response.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  3  opcode; see package.
- req_wide  in  1  1 = 2*REG_WIDTH operation (ADD only).
- req_a  in  2*REG_WIDTH  operand A; upper half ignored when narrow.
- req_b  in  2*REG_WIDTH  operand B; upper half ignored when narrow.
- req_tag  in  TAG_WIDTH  opaque tag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  2*REG_WIDTH  result; upper half 0 when narrow.
- rsp_cout  out  1  final carry out.
- rsp_err  out  1  illegal opcode or illegal wide request.
- rsp_tag  out  TAG_WIDTH  echoed tag.
- alpu_a  out  REG_WIDTH  to alpu_comb a.
- alpu_b  out  REG_WIDTH  to alpu_comb b.
- alpu_ctrl  out  8  to alpu_comb ctrl.
- alpu_cin  out  1  to alpu_comb cin.
- alpu_out  in  REG_WIDTH  from alpu_comb out.
- alpu_cout  in  1  from alpu_comb cout.

Behaviour:
- States: IDLE, EXEC_LO, EXEC_HI, RESP. All outputs and registers are reset asynchronously.
- Reset values: state=IDLE, req_ready=0 while reset_n=0 and 1 after release, rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_err=0, rsp_tag=0, alpu_ctrl=0, alpu_a=0, alpu_b=0, alpu_cin=0.
- req_ready = (state==IDLE). There is no acceptance in any other state.
- IDLE: on handshake, capture op, wide, a, b and tag, then go to EXEC_LO.
- Legality check at capture:
  - op=3'b111, or wide=1 with op≠ADD, sets err.
  - An erroring request skips EXEC and goes directly to RESP with rsp_data=0, rsp_cout=0, rsp_err=1.
- EXEC_LO:
  - Drive alpu_a/alpu_b = low halves, alpu_ctrl = decoded word, alpu_cin=0.
  - At the clock edge, register alpu_out into the result low half and alpu_cout into carry_q.
  - Next state is EXEC_HI if wide, otherwise RESP.
- EXEC_HI:
  - Drive the high halves, alpu_ctrl=CTRL_ADD, alpu_cin=carry_q.
  - At the edge, register the high half and rsp_cout=alpu_cout, then go to RESP.
- Outside EXEC states: alpu_ctrl=0 and alpu_cin=0. alpu_a and alpu_b are don't-care but stable.
- RESP:
  - rsp_valid=1; rsp_data, rsp_cout, rsp_err and rsp_tag are held stable until rsp_ready.
  - On handshake, go to IDLE.
  - rsp_cout for narrow ops equals alpu_cout from EXEC_LO.
- Latency, counting the accept edge as 0:
  - narrow op: rsp_valid at edge 2;
  - wide op: rsp_valid at edge 3;
  - error: rsp_valid at edge 1.
- Throughput: at most one request in flight.
- Ctrl word semantics, bit 7 down to bit 0: twos_en, all_en, cgen_en, or_en, carry_en, sel_sum, sel_cgen, out_inv.
- SUB computes B−A.
- Assertion of reset_n low mid-operation aborts immediately to IDLE and clears all outputs; the in-flight request is dropped without a response.

Optional Feature:
- Macro: ALPU_SEQ_FLAGS_EN.
- Defined: adds outputs rsp_zero (1 when rsp_data==0) and rsp_neg (MSB of the result, i.e. bit 2*REG_WIDTH−1 when wide, bit REG_WIDTH−1 when narrow). Both are registered with rsp_data and reset to 0. Both are 0 when rsp_err=1.
- Undefined: these ports and flops do not exist.

Decomposition:
- Package alpu_seq_pkg holds:
  - alpu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, PASSB=6, ILLEGAL=7;
  - state enum;
  - localparam ctrl words: CTRL_ADD=8'h2C, CTRL_SUB=8'hAC, CTRL_AND=8'h22, CTRL_OR=8'h32, CTRL_XOR=8'h04, CTRL_NOT=8'h44, CTRL_PASSB=8'h24.
- Sub-module alpu_seq_decode: purely combinational, op → ctrl plus illegal flag; reused by future issue logic.

Test Plan:
- Narrow ADD, a=16'h00FF, b=16'h0001, rsp_ready=1 → rsp_valid at edge 2, rsp_data=32'h0000_0100, rsp_cout=0, alpu_ctrl=8'h2C during EXEC_LO, tag echoed.
- Wide ADD, a=32'h0000_FFFF, b=32'h0000_0001 → EXEC_HI drives alpu_cin=1, rsp_data=32'h0001_0000, rsp_cout=0, rsp_valid at edge 3.
- Wide ADD, a=32'hFFFF_FFFF, b=1 → rsp_data=0, rsp_cout=1; with ALPU_SEQ_FLAGS_EN, rsp_zero=1.
- Illegal: op=7, then wide SUB → each gives rsp_err=1, rsp_data=0 at edge 1, and alpu_ctrl stays 0 throughout.
- Back-pressure: hold rsp_ready=0 for 5 cycles after AND a=16'hF0F0, b=16'hFF00 → rsp_data=16'hF000 stable, req_ready=0, and a new req_valid is not accepted until the cycle after the rsp handshake.
- Reset mid wide op: drive reset_n low during EXEC_HI → all outputs 0 immediately; after release req_ready=1, no stale rsp_valid.
